decompress3_7_ser: RTL and testbench

Serial unary expander: the inverse of the 7:3 population-count compressor in the multiplier datapath.
- Accepts a stream of 3-bit counts (0..7) over a valid/ready handshake.
- Emits, for each count, a 7-bit word containing exactly that many ones, bit-serially over a valid/ready handshake.
- A parallel thermometer view of the word in flight is also provided.
- Used to regenerate partial-product bit columns for the multiplier self-test and for reconstructing compressed columns.

---
 rtl/decompress3_7_ser.sv | 146 ++++++++++++++
 tb/tb_decompress3_7_ser.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/decompress3_7_ser.sv
// Serial unary expander: each 3-bit count becomes a 7-beat word with that many ones.
// Optional DECOMP_CHECK_EN adds a sticky err output that cross-checks emitted ones against the count.
module decompress3_7_ser #(
  parameter int DEPTH      = 2,
  parameter bit ONES_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_count,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_bit,
  output logic       out_last,
  output logic [6:0] therm,
  output logic       busy
`ifdef DECOMP_CHECK_EN
  ,
  output logic       err
`endif
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [2:0]      cur_q, cur_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            in_ready_q, in_ready_d;
  logic [2:0]      mem_q [DEPTH];
  logic            push, pop, beat, fifo_ne;

  // Beat k of a word carrying count c; 4-bit compares keep 7-c from wrapping.
  function automatic logic bit_at(input logic [2:0] k, input logic [2:0] c);
    logic [3:0] k4, c4;
    k4 = {1'b0, k};
    c4 = {1'b0, c};
    if (ONES_FIRST) return k4 < c4;
    else            return k4 >= (4'd7 - c4);
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cur_d    = cur_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop      = 1'b0;
    fifo_ne  = (count_q != '0);
    push     = in_valid && in_ready_q;
    beat     = (state_q == SHIFT) && out_ready;
    case (state_q)
      IDLE:  pop = fifo_ne;
      SHIFT: if (beat) begin
        if (idx_q != 3'd6) idx_d = idx_q + 3'd1;
        else if (fifo_ne)  pop = 1'b1;
        else begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      cur_d    = mem_q[rd_ptr_q];
      idx_d    = '0;
      state_d  = SHIFT;
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    count_d    = count_q + CW'(push) - CW'(pop);
    in_ready_d = (count_d != CW'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cur_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cur_q      <= cur_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_count;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == SHIFT);
  assign out_bit   = out_valid && bit_at(idx_q, cur_q);
  assign out_last  = out_valid && (idx_q == 3'd6);
  assign busy      = out_valid || fifo_ne;

  always_comb begin
    therm = '0;
    for (int k = 0; k < 7; k++) therm[k] = out_valid && bit_at(3'(k), cur_q);
  end

`ifdef DECOMP_CHECK_EN
  logic [2:0] ones_q, ones_d;
  logic       err_q, err_d;

  // Compare on the last beat before any new word's pop clears the counter.
  always_comb begin
    ones_d = ones_q;
    err_d  = err_q;
    if (beat) begin
      if (idx_q == 3'd6) begin
        if (({1'b0, ones_q} + {3'b000, out_bit}) != {1'b0, cur_q}) err_d = 1'b1;
        ones_d = '0;
      end else begin
        ones_d = ones_q + {2'b00, out_bit};
      end
    end
    if (pop) ones_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q <= '0;
      err_q  <= 1'b0;
    end else begin
      ones_q <= ones_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`endif
endmodule

// File: tb/tb_decompress3_7_ser.sv
// Directed bench for decompress3_7_ser: ONES_FIRST=1 instance plus a ONES_FIRST=0 instance.
module tb_decompress3_7_ser;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0, in_valid0 = 1'b0;
  logic [2:0] in_count = '0;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid, out_bit, out_last, busy;
  logic       in_ready0, out_valid0, out_bit0, out_last0, busy0;
  logic [6:0] therm, therm0;
`ifdef DECOMP_CHECK_EN
  logic       err, err0;
`endif

  always #5 clk = ~clk;

  decompress3_7_ser #(.DEPTH(2), .ONES_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit), .out_last(out_last),
    .therm(therm), .busy(busy)
`ifdef DECOMP_CHECK_EN
    , .err(err)
`endif
  );

  decompress3_7_ser #(.DEPTH(2), .ONES_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_count(in_count),
    .out_valid(out_valid0), .out_ready(out_ready), .out_bit(out_bit0), .out_last(out_last0),
    .therm(therm0), .busy(busy0)
`ifdef DECOMP_CHECK_EN
    , .err(err0)
`endif
  );

  int checks = 0, failures = 0;
  bit use0 = 1'b0;

  logic       s_valid, s_bit, s_last;
  logic [6:0] s_therm;
  assign s_valid = use0 ? out_valid0 : out_valid;
  assign s_bit   = use0 ? out_bit0   : out_bit;
  assign s_last  = use0 ? out_last0  : out_last;
  assign s_therm = use0 ? therm0     : therm;

  typedef struct {
    logic [2:0] cnt;
    logic [6:0] word;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] c);
    in_count = c;
    if (use0) in_valid0 = 1'b1;
    else      in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    in_valid0 = 1'b0;
  endtask

  task automatic collect(input int n, input bit chk_th, input logic [6:0] th_exp,
                         output logic [13:0] bits, output logic [13:0] lasts,
                         output int gaps, output int th_bad);
    bits = '0; lasts = '0; gaps = 0; th_bad = 0;
    for (int k = 0; k < n; k++) begin
      if (!s_valid) gaps++;
      bits[k]  = s_bit;
      lasts[k] = s_last;
      if (chk_th && s_therm !== th_exp) th_bad++;
      tick();
    end
  endtask

  task automatic run_word(input logic [2:0] c, input logic [6:0] w);
    logic [13:0] bits, lasts;
    int gaps, th_bad;
    push(c);
    chk("latency_still_idle", 32'(s_valid), 32'd0);
    tick();
    collect(7, 1'b1, w, bits, lasts, gaps, th_bad);
    chk("word_bits", 32'(bits[6:0]), 32'(w));
    chk("word_last", 32'(lasts[6:0]), 32'h40);
    chk("word_gaps", 32'(gaps), 32'd0);
    chk("word_therm", 32'(th_bad), 32'd0);
    chk("idle_after", 32'(s_valid), 32'd0);
  endtask

  initial begin
    logic [13:0] bits, lasts;
    int gaps, th_bad;
    logic [3:0] rdy_seq;

    vecs[0] = '{cnt: 3'd0, word: 7'b0000000};
    vecs[1] = '{cnt: 3'd5, word: 7'b0011111};
    vecs[2] = '{cnt: 3'd7, word: 7'b1111111};
    vecs[3] = '{cnt: 3'd1, word: 7'b0000001};
    vecs[4] = '{cnt: 3'd3, word: 7'b0000111};

    #1 rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_therm", 32'(therm), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_word(vecs[i].cnt, vecs[i].word);

    // back-to-back 7 then 0, no bubble
    in_valid = 1'b1; in_count = 3'd7;
    tick();
    in_count = 3'd0;
    tick();
    in_valid = 1'b0;
    collect(14, 1'b0, 7'd0, bits, lasts, gaps, th_bad);
    chk("b2b_bits", 32'(bits), 32'h007F);
    chk("b2b_last", 32'(lasts), 32'h2040);
    chk("b2b_gaps", 32'(gaps), 32'd0);
    chk("b2b_idle", 32'(out_valid), 32'd0);

    // stall on beat 3 of count 3
    push(3'd3);
    tick(); tick(); tick();
    out_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_bit", 32'(out_bit), 32'd1);
      chk("stall_last", 32'(out_last), 32'd0);
      chk("stall_therm", 32'(therm), 32'h07);
      if (s < 3) tick();
    end
    out_ready = 1'b1;
    collect(5, 1'b1, 7'b0000111, bits, lasts, gaps, th_bad);
    chk("stall_resume_bits", 32'(bits[4:0]), 32'h01);
    chk("stall_resume_last", 32'(lasts[4:0]), 32'h10);
    chk("stall_resume_gaps", 32'(gaps), 32'd0);
    chk("stall_idle", 32'(out_valid), 32'd0);

    // capacity: 2 queued + 1 in flight
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rdy_seq[i] = in_ready;
      in_valid = 1'b1; in_count = 3'(i + 2);
      tick();
    end
    in_valid = 1'b0;
    chk("cap_ready_seq", 32'(rdy_seq), 32'h7);
    chk("cap_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("cap_full_before_pop", 32'(in_ready), 32'd0);
    tick();
    chk("cap_ready_after_pop", 32'(in_ready), 32'd1);
    chk("cap_fifo_order", 32'(therm), 32'h07);
    for (int i = 0; i < 60 && busy; i++) tick();
    chk("cap_drained", 32'(busy), 32'd0);

    // reset mid-word with a queued count
    out_ready = 1'b0;
    push(3'd6);
    push(3'd1);
    out_ready = 1'b1;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_bit", 32'(out_bit), 32'd0);
    chk("midrst_out_last", 32'(out_last), 32'd0);
    chk("midrst_therm", 32'(therm), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("midrst_no_resume", 32'(out_valid), 32'd0);
    chk("midrst_not_busy", 32'(busy), 32'd0);

    // zeros-first ordering
    use0 = 1'b1;
    run_word(3'd2, 7'b1100000);
    run_word(3'd6, 7'b1111110);

`ifdef DECOMP_CHECK_EN
    chk("err_clean", 32'(err0), 32'd0);
    push(3'd2);
    tick();
    for (int i = 0; i < 6; i++) tick();
    force dut0.out_bit = 1'b0;
    tick();
    release dut0.out_bit;
    chk("err_set", 32'(err0), 32'd1);
    tick(); tick(); tick();
    chk("err_sticky", 32'(err0), 32'd1);
    rst = 1'b1;
    #1;
    chk("err_rst", 32'(err0), 32'd0);
    tick();
    rst = 1'b0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
